// File: rtl/calc_pkg.sv
// ============================================================================
//  Module   : calc_pkg
//  Brief    : Shared types, key codes and key decode for the calculator
//             entry controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    // Operator latched between operand entries
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5
    } op_t;

    // Entry phase: first operand, operator chosen, second operand, result
    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_OP  = 2'd1,
        S_B   = 2'd2,
        S_RES = 2'd3
    } state_t;

    // Non-digit key codes delivered by the keypad cursor
    localparam logic [4:0] KEY_ADD = 5'h10;
    localparam logic [4:0] KEY_MUL = 5'h11;
    localparam logic [4:0] KEY_AND = 5'h12;
    localparam logic [4:0] KEY_EXE = 5'h13;
    localparam logic [4:0] KEY_SUB = 5'h14;
    localparam logic [4:0] KEY_OR  = 5'h15;
    localparam logic [4:0] KEY_CE  = 5'h16;
    localparam logic [4:0] KEY_CLR = 5'h17;

    // Map an operator key to its op_t; every other code yields OP_NONE
    function automatic op_t key_to_op(input logic [4:0] key);
        case (key)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_AND: return OP_AND;
            KEY_OR:  return OP_OR;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_entry_fsm_if.sv
// ============================================================================
//  Module   : calc_entry_fsm_if
//  Brief    : Key strobe in / display and status out bundle between the
//             keypad cursor side (master) and the entry controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_entry_fsm_if #(
    parameter int W = 16
) ();

    logic                 select;
    logic [4:0]           val;
    logic [W-1:0]         disp;
    calc_pkg::state_t     state;
    calc_pkg::op_t        op_pend;
    logic                 ovf;
    logic                 done;
    logic                 restriction;

    // Keypad / cursor side
    modport master (
        output select,
        output val,
        input  disp,
        input  state,
        input  op_pend,
        input  ovf,
        input  done,
        input  restriction
    );

    // Entry controller side
    modport slave (
        input  select,
        input  val,
        output disp,
        output state,
        output op_pend,
        output ovf,
        output done,
        output restriction
    );

endinterface

`default_nettype wire

// File: rtl/calc_alu.sv
// ============================================================================
//  Module   : calc_alu
//  Brief    : Combinational W-bit ALU. Result wraps mod 2^W; ovf reports
//             ADD carry-out, SUB borrow, MUL non-zero upper half.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_alu
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic [W-1:0] a,
    input  wire logic [W-1:0] b,
    input  wire op_t          op,
    output logic [W-1:0]      res,
    output logic              ovf
);

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_prod;

    // Extra top bit of the difference is set exactly when a < b
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    // Select result and flag by operator; OP_NONE passes a through
    always_comb begin
        res = a;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin res = w_sum[W-1:0];  ovf = w_sum[W];          end
            OP_SUB: begin res = w_diff[W-1:0]; ovf = w_diff[W];         end
            OP_MUL: begin res = w_prod[W-1:0]; ovf = |w_prod[2*W-1:W];  end
            OP_AND: begin res = a & b;         ovf = 1'b0;              end
            OP_OR:  begin res = a | b;         ovf = 1'b0;              end
            default: begin res = a;            ovf = 1'b0;              end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/calc_entry_fsm.sv
// ============================================================================
//  Module   : calc_entry_fsm
//  Brief    : Calculator entry controller. Samples key codes on select,
//             builds operands A/B, latches the operator and computes results.
//             Build option CALC_DECIMAL_EN: decimal entry (base 10, digits
//             0x0A-0x0F ignored, cursor restricted to decimal keys);
//             otherwise hexadecimal entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    calc_entry_fsm_if.slave   bus
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

`ifdef CALC_DECIMAL_EN
    localparam logic [W-1:0] c_base     = W'(10);
    localparam logic         c_decimal  = 1'b1;
`else
    localparam logic [W-1:0] c_base     = W'(16);
    localparam logic         c_decimal  = 1'b0;
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    op_t             op_q, op_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [W-1:0]    disp_q, disp_d;

    logic [W-1:0]    w_digit;
    logic            w_is_digit;
    op_t             w_key_op;
    logic            w_is_op;
    logic            w_key_exe;
    logic            w_key_ce;
    logic            w_clear_all;
    logic            w_cnt_room;
    logic [W-1:0]    w_a_acc;
    logic [W-1:0]    w_b_acc;
    logic [W-1:0]    w_alu_a;
    logic [W-1:0]    w_alu_res;
    logic            w_alu_ovf;

    // Key classification; codes 0x18-0x1F fall into no class and are ignored
    assign w_digit     = W'(bus.val[3:0]);
    assign w_is_digit  = ~bus.val[4] & (~c_decimal | (bus.val[3:0] < 4'd10));
    assign w_key_op    = key_to_op(bus.val);
    assign w_is_op     = (w_key_op != OP_NONE);
    assign w_key_exe   = (bus.val == KEY_EXE);
    assign w_key_ce    = (bus.val == KEY_CE);
    assign w_clear_all = bus.select &
                         ((bus.val == KEY_CLR) | (w_key_ce & (state_q == S_RES)));

    // Digit accumulation, truncated to W bits
    assign w_cnt_room  = (cnt_q < CW'(MAX_DIGITS));
    assign w_a_acc     = a_q * c_base + w_digit;
    assign w_b_acc     = b_q * c_base + w_digit;

    // A repeated EXE in the result phase reuses R as the left operand
    assign w_alu_a     = (state_q == S_RES) ? r_q : a_q;

    calc_alu #(
        .W   (W)
    ) u_alu (
        .a   (w_alu_a),
        .b   (b_q),
        .op  (op_q),
        .res (w_alu_res),
        .ovf (w_alu_ovf)
    );

    // Next-state and datapath update for one sampled key strobe
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        if (w_clear_all) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            cnt_d   = '0;
            op_d    = OP_NONE;
            ovf_d   = 1'b0;
        end else if (bus.select) begin
            case (state_q)
                S_A: begin
                    if (w_is_digit) begin
                        if (w_cnt_room) begin
                            a_d   = w_a_acc;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (w_is_op) begin
                        op_d    = w_key_op;
                        state_d = S_OP;
                    end else if (w_key_ce) begin
                        a_d   = '0;
                        cnt_d = '0;
                    end
                end
                S_OP: begin
                    if (w_is_digit) begin
                        b_d     = w_digit;
                        cnt_d   = CW'(1);
                        state_d = S_B;
                    end else if (w_is_op) begin
                        op_d = w_key_op;
                    end else if (w_key_ce) begin
                        op_d    = OP_NONE;
                        state_d = S_A;
                    end
                end
                S_B: begin
                    if (w_is_digit) begin
                        if (w_cnt_room) begin
                            b_d   = w_b_acc;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (w_key_exe) begin
                        r_d     = w_alu_res;
                        ovf_d   = w_alu_ovf;
                        done_d  = 1'b1;
                        state_d = S_RES;
                    end else if (w_is_op) begin
                        // Chained operator: fold the pending result into A
                        a_d     = w_alu_res;
                        ovf_d   = w_alu_ovf;
                        op_d    = w_key_op;
                        done_d  = 1'b1;
                        state_d = S_OP;
                    end else if (w_key_ce) begin
                        b_d   = '0;
                        cnt_d = '0;
                    end
                end
                S_RES: begin
                    if (w_is_digit) begin
                        a_d     = w_digit;
                        cnt_d   = CW'(1);
                        ovf_d   = 1'b0;
                        state_d = S_A;
                    end else if (w_is_op) begin
                        a_d     = r_q;
                        op_d    = w_key_op;
                        state_d = S_OP;
                    end else if (w_key_exe) begin
                        r_d    = w_alu_res;
                        ovf_d  = w_alu_ovf;
                        done_d = 1'b1;
                    end
                end
                default: state_d = S_A;
            endcase
        end

        case (state_d)
            S_B:     disp_d = b_d;
            S_RES:   disp_d = r_d;
            default: disp_d = a_d;
        endcase
    end

    // State and registered outputs; reset overrides any key strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.disp        = disp_q;
    assign bus.state       = state_q;
    assign bus.op_pend     = op_q;
    assign bus.ovf         = ovf_q;
    assign bus.done        = done_q;
    assign bus.restriction = c_decimal;

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_fsm.sv
// ============================================================================
//  Module   : tb_calc_entry_fsm
//  Brief    : Self-checking bench for calc_entry_fsm: arithmetic reference
//             model compared every cycle plus literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_entry_fsm;

    localparam int  W    = 16;
    localparam longint MOD = 65536;
`ifdef CALC_DECIMAL_EN
    localparam int  BASE = 10;
    localparam bit  DEC  = 1'b1;
`else
    localparam int  BASE = 16;
    localparam bit  DEC  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    calc_entry_fsm_if #(.W(W)) bus ();

    calc_entry_fsm #(
        .W          (W),
        .MAX_DIGITS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic strobe_done;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase numbers: 0 entering A, 1 operator chosen, 2 entering B, 3 result shown
    longint m_a, m_b, m_r;
    int     m_cnt, m_op, m_ph;
    bit     m_ovf, m_done;

    function automatic void arith(input longint x, input longint y, input int op,
                                  output longint r, output bit o);
        longint t;
        o = 1'b0;
        t = x;
        case (op)
            1: begin t = x + y; o = (t >= MOD); end
            2: begin o = (x < y); t = x - y + MOD; end
            3: begin t = x * y; o = (t >= MOD); end
            4: t = x & y;
            5: t = x | y;
            default: t = x;
        endcase
        r = t % MOD;
    endfunction

    function automatic int op_of(input int k);
        case (k)
            'h10: return 1;
            'h14: return 2;
            'h11: return 3;
            'h12: return 4;
            'h15: return 5;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_r = 0; m_cnt = 0; m_op = 0; m_ph = 0; m_ovf = 0;
    endtask

    always @(posedge clk) begin
        int k;
        bit dig;
        int opk;
        longint res;
        bit o;
        m_done = 1'b0;
        k = int'(bus.val);
        dig = (k < 16) && (!DEC || k < 10);
        opk = op_of(k);
        if (rst) begin
            model_clear();
        end else if (bus.select) begin
            if (k == 'h17 || (k == 'h16 && m_ph == 3)) begin
                model_clear();
            end else if (m_ph == 0) begin
                if (dig) begin
                    if (m_cnt < 4) begin m_a = (m_a * BASE + k) % MOD; m_cnt++; end
                end else if (opk != 0) begin m_op = opk; m_ph = 1; end
                else if (k == 'h16) begin m_a = 0; m_cnt = 0; end
            end else if (m_ph == 1) begin
                if (dig) begin m_b = k; m_cnt = 1; m_ph = 2; end
                else if (opk != 0) m_op = opk;
                else if (k == 'h16) begin m_op = 0; m_ph = 0; end
            end else if (m_ph == 2) begin
                if (dig) begin
                    if (m_cnt < 4) begin m_b = (m_b * BASE + k) % MOD; m_cnt++; end
                end else if (k == 'h13) begin
                    arith(m_a, m_b, m_op, res, o);
                    m_r = res; m_ovf = o; m_done = 1; m_ph = 3;
                end else if (opk != 0) begin
                    arith(m_a, m_b, m_op, res, o);
                    m_a = res; m_ovf = o; m_op = opk; m_done = 1; m_ph = 1;
                end else if (k == 'h16) begin m_b = 0; m_cnt = 0; end
            end else begin
                if (dig) begin m_a = k; m_cnt = 1; m_ovf = 0; m_ph = 0; end
                else if (opk != 0) begin m_a = m_r; m_op = opk; m_ph = 1; end
                else if (k == 'h13) begin
                    arith(m_r, m_b, m_op, res, o);
                    m_r = res; m_ovf = o; m_done = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        longint exp_disp;
        if (chk_en) begin
            exp_disp = (m_ph == 2) ? m_b : (m_ph == 3) ? m_r : m_a;
            check("disp",        bus.disp,             exp_disp);
            check("state",       int'(bus.state),      m_ph);
            check("op_pend",     int'(bus.op_pend),    m_op);
            check("ovf",         bus.ovf,              m_ovf);
            check("done",        bus.done,             m_done);
            check("restriction", bus.restriction,      DEC);
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [4:0] k);
        bus.select = 1'b1;
        bus.val    = k;
        @(posedge clk); #1;
        strobe_done = bus.done;
        bus.select = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic press_seq(input logic [4:0] ks[$]);
        foreach (ks[i]) press(ks[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.select = 1'b0;
        bus.val    = 5'h00;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        check("rst_disp",  bus.disp, 0);
        check("rst_state", int'(bus.state), 0);
        check("rst_op",    int'(bus.op_pend), 0);
        check("rst_ovf",   bus.ovf, 0);
        check("rst_done",  bus.done, 0);

        // 1: 1,2,ADD,3,EXE
        press_seq('{5'h01, 5'h02, 5'h10, 5'h03, 5'h13});
        check("t1_disp",  bus.disp, DEC ? 15 : 'h15);
        check("t1_state", int'(bus.state), 3);
        check("t1_done_pulse", strobe_done, 1);
        check("t1_done_low", bus.done, 0);
        check("t1_ovf",   bus.ovf, 0);

        // 2: chain 5,SUB,2,MUL,4,EXE then 1,SUB,2,EXE
        press(5'h17);
        press_seq('{5'h05, 5'h14, 5'h02, 5'h11});
        check("t2_chain_a", bus.disp, 3);
        check("t2_chain_state", int'(bus.state), 1);
        check("t2_chain_done", strobe_done, 1);
        press_seq('{5'h04, 5'h13});
        check("t2_disp", bus.disp, 'h000C);
        press_seq('{5'h01, 5'h14, 5'h02, 5'h13});
        check("t2_borrow_disp", bus.disp, 'hFFFF);
        check("t2_borrow_ovf",  bus.ovf, 1);

        // 3: digit limit, CE, ignored code
        press(5'h17);
        check("t3_clr_ovf", bus.ovf, 0);
        press_seq('{5'h01, 5'h02, 5'h03, 5'h04, 5'h05});
        check("t3_limit", bus.disp, DEC ? 1234 : 'h1234);
        press(5'h16);
        check("t3_ce", bus.disp, 0);
        press(5'h19);
        check("t3_ign_disp",  bus.disp, 0);
        check("t3_ign_state", int'(bus.state), 0);
        press(5'h07);
        check("t3_after_ce", bus.disp, 7);

        // 4: repeat EXE then a fresh digit
        press(5'h17);
        press_seq('{5'h02, 5'h10, 5'h03, 5'h13});
        check("t4_first", bus.disp, 5);
        press(5'h13);
        check("t4_repeat", bus.disp, 8);
        check("t4_repeat_done", strobe_done, 1);
        press(5'h07);
        check("t4_state", int'(bus.state), 0);
        check("t4_a", bus.disp, 7);
        check("t4_ovf", bus.ovf, 0);

        // CE inside S_OP and S_B, operator replacement, AND/OR chain
        press(5'h17);
        press_seq('{5'h09, 5'h10, 5'h11, 5'h16});
        check("ce_op_state", int'(bus.state), 0);
        check("ce_op_op", int'(bus.op_pend), 0);
        press_seq('{5'h12, 5'h05, 5'h16, 5'h03, 5'h15, 5'h04, 5'h13});
        check("and_or", bus.disp, 5);

        // 5: reset during entry, with a simultaneous key strobe
        press(5'h17);
        press_seq('{5'h09, 5'h11, 5'h04});
        bus.select = 1'b1;
        bus.val    = 5'h05;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.select = 1'b0;
        check("t5_disp",  bus.disp, 0);
        check("t5_state", int'(bus.state), 0);
        check("t5_op",    int'(bus.op_pend), 0);
        check("t5_ovf",   bus.ovf, 0);
        check("t5_done",  bus.done, 0);
        @(posedge clk); #1;

`ifdef CALC_DECIMAL_EN
        // 6: decimal entry
        press_seq('{5'h01, 5'h02});
        check("t6_dec", bus.disp, 'h000C);
        press(5'h0A);
        check("t6_ign_a", bus.disp, 'h000C);
        check("t6_restr", bus.restriction, 1);
`else
        // 6: hex entry, multiply overflow
        press_seq('{5'h0F, 5'h0F, 5'h0F, 5'h0F, 5'h11, 5'h02, 5'h13});
        check("t6_mul_res", bus.disp, 'hFFFE);
        check("t6_mul_ovf", bus.ovf, 1);
        check("t6_restr", bus.restriction, 0);
        press(5'h03);
        check("t6_digit_clr_ovf", bus.ovf, 0);
        press(5'h0A);
        check("t6_hex_a", bus.disp, 'h3A);
`endif

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
